// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-side main-memory line bus initiator.
package mem_bus_pkg;

    localparam int TAG_W  = 10;
    localparam int SET_W  = 5;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 16;
    localparam int BEATS  = 8;

    // Commands carried on the line bus in either direction
    typedef enum logic [2:0] {
        CMD_NOP        = 3'd0,
        CMD_RESPONSE   = 3'd1,
        CMD_READ_LINE  = 3'd2,
        CMD_WRITE_LINE = 3'd3
    } mem_cmd_e;

    // Initiator transaction states
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_READ_CMD    = 3'd1,
        ST_WRITE_BEATS = 3'd2,
        ST_RECV        = 3'd3,
        ST_WRITE_WAIT  = 3'd4,
        ST_DONE        = 3'd5
    } bus_state_e;

    // Any code other than RESPONSE is treated as an idle bus cycle
    function automatic logic is_response(input logic [2:0] cmd);
        return (cmd == CMD_RESPONSE);
    endfunction

endpackage

// File: rtl/mem_line_shifter.sv
// Line-wide shift register shared by the write (beat out) and read (beat in) paths.
module mem_line_shifter #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_data,
    input  logic              shift_out,
    input  logic              shift_in,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] line_r;

    // Load has priority; both shifts move earlier beats up toward the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_r <= {LINE_W{1'b0}};
        end else if (load) begin
            line_r <= load_data;
        end else if (shift_in) begin
            line_r <= {line_r[LINE_W-BEAT_W-1:0], beat_in};
        end else if (shift_out) begin
            line_r <= {line_r[LINE_W-BEAT_W-1:0], {BEAT_W{1'b0}}};
        end else begin
            line_r <= line_r;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/mem_bus_master.sv
// Cache-side initiator: issues READ_LINE / WRITE_LINE as eight 16-bit beats and
// gathers the memory's RESPONSE beats, with an idle-cycle timeout per beat.
module mem_bus_master #(
    parameter int TAG_W   = mem_bus_pkg::TAG_W,
    parameter int SET_W   = mem_bus_pkg::SET_W,
    parameter int LINE_W  = mem_bus_pkg::LINE_W,
    parameter int BEAT_W  = mem_bus_pkg::BEAT_W,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic [SET_W-1:0]       req_set,
    input  logic [LINE_W-1:0]      req_line,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [LINE_W-1:0]      resp_line,
    output logic [TAG_W+SET_W-1:0] mem_a,
    output logic [2:0]             mem_c,
    output logic [BEAT_W-1:0]      mem_d,
    input  logic [2:0]             mem_c_in,
    input  logic [BEAT_W-1:0]      mem_d_in
);

    import mem_bus_pkg::*;

    localparam int         ADDR_W    = TAG_W + SET_W;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    bus_state_e        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        beat_cnt_r;
    logic [7:0]        tmo_cnt_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [LINE_W-1:0] resp_line_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic [2:0]        mem_c_r;
    logic [BEAT_W-1:0] mem_d_r;

    logic              sh_load_s;
    logic [LINE_W-1:0] sh_load_data_s;
    logic              sh_out_s;
    logic              sh_in_s;
    logic [LINE_W-1:0] line_s;
    logic              is_resp_s;
    logic              tmo_hit_s;

    assign is_resp_s = is_response(mem_c_in);
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    mem_line_shifter #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (R),
        .load      (sh_load_s),
        .load_data (sh_load_data_s),
        .shift_out (sh_out_s),
        .shift_in  (sh_in_s),
        .beat_in   (mem_d_in),
        .line      (line_s)
    );

    // Shifter control: load on accept (zeros for reads), shift out while
    // sending write beats, shift in on every captured read beat
    always_comb begin
        sh_load_s      = 1'b0;
        sh_load_data_s = {LINE_W{1'b0}};
        sh_out_s       = 1'b0;
        sh_in_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    sh_load_s      = 1'b1;
                    sh_load_data_s = req_write ? req_line : {LINE_W{1'b0}};
                end else begin
                    sh_load_s      = 1'b0;
                end
            end
            ST_WRITE_BEATS: sh_out_s = 1'b1;
            ST_RECV:        sh_in_s  = is_resp_s;
            default: begin
                sh_load_s = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            beat_cnt_r   <= 3'd0;
            tmo_cnt_r    <= 8'd0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_line_r  <= {LINE_W{1'b0}};
            mem_a_r      <= {ADDR_W{1'b0}};
            mem_c_r      <= CMD_NOP;
            mem_d_r      <= {BEAT_W{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r     <= {req_tag, req_set};
                        mem_a_r    <= {req_tag, req_set};
                        beat_cnt_r <= 3'd0;
                        tmo_cnt_r  <= 8'd0;
                        if (req_write) begin
                            state_r <= ST_WRITE_BEATS;
                            mem_c_r <= CMD_WRITE_LINE;
                            mem_d_r <= req_line[LINE_W-1 -: BEAT_W];
                        end else begin
                            state_r <= ST_READ_CMD;
                            mem_c_r <= CMD_READ_LINE;
                        end
                    end
                end
                ST_READ_CMD: begin
                    state_r    <= ST_RECV;
                    mem_c_r    <= CMD_NOP;
                    mem_a_r    <= {ADDR_W{1'b0}};
                    beat_cnt_r <= 3'd0;
                    tmo_cnt_r  <= 8'd0;
                end
                ST_WRITE_BEATS: begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_r    <= ST_WRITE_WAIT;
                        mem_c_r    <= CMD_NOP;
                        mem_a_r    <= {ADDR_W{1'b0}};
                        mem_d_r    <= {BEAT_W{1'b0}};
                        beat_cnt_r <= 3'd0;
                        tmo_cnt_r  <= 8'd0;
                    end else begin
                        beat_cnt_r <= beat_cnt_r + 3'd1;
                        mem_a_r    <= addr_r;
                        mem_d_r    <= line_s[LINE_W-BEAT_W-1 -: BEAT_W];
                    end
                end
                ST_RECV: begin
                    if (is_resp_s) begin
                        tmo_cnt_r <= 8'd0;
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r      <= ST_DONE;
                            resp_valid_r <= 1'b1;
                            resp_line_r  <= {line_s[LINE_W-BEAT_W-1:0], mem_d_in};
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 3'd1;
                        end
                    end else if (tmo_hit_s) begin
                        // Captured beats sit in the low end; move them to their line slots
                        tmo_cnt_r    <= tmo_cnt_r + 8'd1;
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_line_r  <= line_s << (BEAT_W * (BEATS - int'(beat_cnt_r)));
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (is_resp_s) begin
                        tmo_cnt_r    <= 8'd0;
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_r    <= tmo_cnt_r + 8'd1;
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_c_r <= CMD_NOP;
                    mem_a_r <= {ADDR_W{1'b0}};
                    mem_d_r <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

    assign req_ready  = (state_r == ST_IDLE) && !R;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_line  = resp_line_r;
    assign mem_a      = mem_a_r;
    assign mem_c      = mem_c_r;
    assign mem_d      = mem_d_r;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed scenarios plus randomized transactions,
// checked every cycle against a transaction-level model of the line bus.
module tb_mem_bus_master;

    localparam int TAG_W   = 10;
    localparam int SET_W   = 5;
    localparam int LINE_W  = 128;
    localparam int BEAT_W  = 16;
    localparam int TIMEOUT = 255;

    logic                   clk = 1'b0;
    logic                   R = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_write = 1'b0;
    logic [TAG_W-1:0]       req_tag = '0;
    logic [SET_W-1:0]       req_set = '0;
    logic [LINE_W-1:0]      req_line = '0;
    logic                   req_ready;
    logic                   resp_valid;
    logic                   resp_err;
    logic [LINE_W-1:0]      resp_line;
    logic [TAG_W+SET_W-1:0] mem_a;
    logic [2:0]             mem_c;
    logic [BEAT_W-1:0]      mem_d;
    logic [2:0]             mem_c_in = 3'd0;
    logic [BEAT_W-1:0]      mem_d_in = 16'd0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_master #(
        .TAG_W(TAG_W), .SET_W(SET_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .R(R),
        .req_valid(req_valid), .req_write(req_write), .req_tag(req_tag),
        .req_set(req_set), .req_line(req_line), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
        .mem_a(mem_a), .mem_c(mem_c), .mem_d(mem_d),
        .mem_c_in(mem_c_in), .mem_d_in(mem_d_in)
    );

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int                     e = 0;
    bit                     m_busy = 1'b0;
    bit                     m_done = 1'b0;
    bit                     m_wr = 1'b0;
    logic [TAG_W+SET_W-1:0] m_addr = '0;
    logic [LINE_W-1:0]      m_line = '0;
    int                     m_t0 = 0;
    int                     m_got = 0;
    int                     m_idle = 0;
    logic [BEAT_W-1:0]      m_beats [8];
    int                     acc_cnt = 0;
    int                     aborted = 0;
    int                     resp_cnt = 0;
    logic                   exp_rv = 1'b0;
    logic                   exp_err = 1'b0;
    logic [LINE_W-1:0]      exp_line = '0;
    logic [2:0]             exp_c = 3'd0;
    logic [TAG_W+SET_W-1:0] exp_a = '0;
    logic [BEAT_W-1:0]      exp_d = '0;

    // Expected outputs for the cycle after each edge, from cycle offsets since accept
    initial begin
        int n;
        forever begin
            @(posedge clk);
            e++;
            if (R) begin
                if (m_busy && !m_done) aborted++;
                m_busy = 1'b0; m_done = 1'b0;
                exp_rv = 1'b0; exp_err = 1'b0;
                exp_c = 3'd0; exp_a = '0; exp_d = '0;
            end else begin
                exp_rv = 1'b0;
                exp_err = 1'b0;
                if (m_done) begin
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end else if (!m_busy) begin
                    if (req_valid) begin
                        m_busy = 1'b1; m_wr = req_write; m_addr = {req_tag, req_set};
                        m_line = req_line; m_t0 = e; m_got = 0; m_idle = 0;
                        for (int k = 0; k < 8; k++) m_beats[k] = '0;
                        acc_cnt++;
                    end
                end else begin
                    n = e - m_t0;
                    // writes listen from edge 9, reads from edge 2
                    if (n >= (m_wr ? 9 : 2)) begin
                        if (mem_c_in == 3'd1) begin
                            m_idle = 0;
                            if (!m_wr) begin
                                m_beats[m_got] = mem_d_in;
                                m_got++;
                            end
                            if (m_wr || m_got == 8) begin
                                m_done = 1'b1; exp_rv = 1'b1; exp_err = 1'b0;
                            end
                        end else begin
                            m_idle++;
                            if (m_idle == TIMEOUT) begin
                                m_done = 1'b1; exp_rv = 1'b1; exp_err = 1'b1;
                            end
                        end
                        if (m_done) begin
                            for (int k = 0; k < 8; k++) exp_line[127-16*k -: 16] = m_beats[k];
                        end
                    end
                end
                n = e - m_t0;
                exp_c = 3'd0; exp_a = '0; exp_d = '0;
                if (m_busy && !m_done) begin
                    if (m_wr && n <= 7) begin
                        exp_c = 3'd3; exp_a = m_addr; exp_d = m_line[127-16*n -: 16];
                    end else if (!m_wr && n == 0) begin
                        exp_c = 3'd2; exp_a = m_addr;
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (R) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_line", resp_line, 0);
                chk("rst_mem_c", mem_c, 0);
                chk("rst_mem_a", mem_a, 0);
                chk("rst_mem_d", mem_d, 0);
            end else begin
                if (resp_valid) resp_cnt++;
                chk("req_ready", req_ready, !m_busy);
                chk("resp_valid", resp_valid, exp_rv);
                chk("mem_c", mem_c, exp_c);
                chk("mem_a", mem_a, exp_a);
                chk("mem_d", mem_d, exp_d);
                if (exp_rv) begin
                    chk("resp_err", resp_err, exp_err);
                    if (!m_wr) chk("resp_line", resp_line, exp_line);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle_mem();
        int r;
        r = $urandom_range(0, 4);
        mem_c_in = (r == 0) ? 3'd0 : 3'(r + 3);
        mem_d_in = 16'($urandom);
    endtask

    task automatic drive_stray();
        mem_c_in = 3'($urandom_range(0, 7));
        mem_d_in = 16'($urandom);
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 0;
        else if (r < 96) return $urandom_range(1, 6);
        else if (r < 98) return TIMEOUT - 1;
        else return TIMEOUT;
    endfunction

    task automatic run_txn(input bit wr, input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                           input logic [LINE_W-1:0] line, input bit hold);
        int w;
        int g;
        bit done;
        w = 0;
        while (!req_ready && w < 600) begin
            drive_stray();
            tick();
            w++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL idle_wait: req_ready 0 after %0d cycles, expected 1", w);
            return;
        end
        drive_stray();
        req_valid = 1'b1; req_write = wr; req_tag = tag; req_set = set; req_line = line;
        tick();
        req_valid = hold;
        for (int c = 0; c < (wr ? 8 : 1); c++) begin
            drive_stray();
            tick();
        end
        done = 1'b0;
        for (int b = 0; b < (wr ? 1 : 8) && !done; b++) begin
            g = pick_gap();
            for (int j = 0; j < g && !done; j++) begin
                drive_idle_mem();
                tick();
                done = resp_valid;
            end
            if (!done) begin
                mem_c_in = 3'd1;
                mem_d_in = 16'($urandom);
                tick();
                done = resp_valid;
            end
        end
        mem_c_in = 3'd0;
        req_valid = 1'b0;
    endtask

    logic [LINE_W-1:0] wline;
    logic [BEAT_W-1:0] wbeats [8];
    logic [LINE_W-1:0] rline;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        wline = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        wbeats = '{16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
        rline = 128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7;

        // reset state
        repeat (3) tick();
        chk("lit_reset_ready", req_ready, 0);
        chk("lit_reset_line", resp_line, 0);
        R = 1'b0;
        #1;
        chk("lit_ready_after_reset", req_ready, 1);
        tick();

        // directed write
        req_valid = 1'b1; req_write = 1'b1; req_tag = 10'h3A5; req_set = 5'h11; req_line = wline;
        tick();
        req_valid = 1'b0;
        chk("lit_wr_cmd", mem_c, 3'd3);
        chk("lit_wr_addr", mem_a, 15'h74B1);
        for (int k = 0; k < 8; k++) begin
            chk("lit_wr_beat", mem_d, wbeats[k]);
            tick();
        end
        chk("lit_wr_nop_after", mem_c, 3'd0);
        mem_c_in = 3'd1;
        tick();
        mem_c_in = 3'd0;
        chk("lit_wr_resp_valid", resp_valid, 1);
        chk("lit_wr_resp_err", resp_err, 0);
        tick();
        chk("lit_wr_ready_again", req_ready, 1);

        // directed read, back-to-back beats
        req_valid = 1'b1; req_write = 1'b0; req_tag = 10'h001; req_set = 5'h02;
        tick();
        req_valid = 1'b0;
        chk("lit_rd_cmd", mem_c, 3'd2);
        chk("lit_rd_addr", mem_a, 15'h0022);
        tick();
        for (int k = 0; k < 8; k++) begin
            mem_c_in = 3'd1;
            mem_d_in = {8'(8'hA0 + k), 8'(8'hA0 + k)};
            tick();
        end
        mem_c_in = 3'd0;
        chk("lit_rd_resp_valid", resp_valid, 1);
        chk("lit_rd_resp_line", resp_line, rline);
        chk("lit_rd_resp_err", resp_err, 0);
        tick();

        // stray RESPONSE while idle
        mem_c_in = 3'd1;
        repeat (3) tick();
        mem_c_in = 3'd0;
        chk("lit_stray_no_resp", resp_valid, 0);
        chk("lit_stray_ready", req_ready, 1);

        // read with a 3-cycle gap between beats 3 and 4, req_valid held while busy
        req_valid = 1'b1; req_write = 1'b0; req_tag = 10'h2F0; req_set = 5'h1F;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                mem_c_in = 3'd0;
                repeat (3) tick();
            end
            if (k == 7) chk("lit_gap_not_yet", resp_valid, 0);
            mem_c_in = 3'd1;
            mem_d_in = {8'(8'hA0 + k), 8'(8'hA0 + k)};
            tick();
        end
        mem_c_in = 3'd0;
        req_valid = 1'b0;
        chk("lit_gap_resp_valid", resp_valid, 1);
        chk("lit_gap_resp_line", resp_line, rline);
        chk("lit_gap_resp_err", resp_err, 0);
        tick();

        // write with the memory silent: timeout 255 cycles into WRITE_WAIT
        req_valid = 1'b1; req_write = 1'b1; req_tag = 10'h155; req_set = 5'h0A; req_line = wline;
        tick();
        req_valid = 1'b0;
        repeat (8) tick();
        repeat (TIMEOUT - 1) tick();
        chk("lit_tmo_not_yet", resp_valid, 0);
        tick();
        chk("lit_tmo_resp_valid", resp_valid, 1);
        chk("lit_tmo_resp_err", resp_err, 1);
        tick();

        // reset during beat 4 of a write
        req_valid = 1'b1; req_write = 1'b1; req_tag = 10'h3A5; req_set = 5'h11; req_line = wline;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("lit_abort_beat4", mem_d, 16'h8899);
        R = 1'b1;
        #1;
        chk("lit_abort_mem_c", mem_c, 3'd0);
        chk("lit_abort_mem_d", mem_d, 16'h0000);
        chk("lit_abort_ready", req_ready, 0);
        tick();
        tick();
        R = 1'b0;
        #1;
        chk("lit_abort_ready_after", req_ready, 1);
        mem_c_in = 3'd1;
        repeat (3) tick();
        mem_c_in = 3'd0;
        chk("lit_abort_no_resp", resp_valid, 0);
        run_txn(1'b0, 10'h0AB, 5'h07, '0, 1'b0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 10'($urandom), 5'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end
        repeat (4) tick();

        chk("resp_pulse_count", resp_cnt, acc_cnt - aborted);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
